// File: rtl/legv8_pkg.sv
// LEGv8 decode definitions shared by the decode stage, its control decoder and the bench.
package legv8_pkg;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b1001000100?;
    localparam logic [10:0] OP_SUBI = 11'b1101000100?;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_B    = 11'b000101?????;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_CBNZ = 11'b10110101???;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_D, IMM_CB, IMM_B} imm_sel_e;

    typedef struct packed {
        logic       reg2loc;
        logic       uses_rs2;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       b;
        logic       cbz;
        logic       cbnz;
    } ctrl_t;

    // The immediate format follows from the instruction class bits, so it is
    // recovered from the 12-bit word instead of occupying extra bits.
    function automatic imm_sel_e imm_sel(input ctrl_t c);
        if (c.b)                      return IMM_B;
        if (c.cbz || c.cbnz)          return IMM_CB;
        if (c.mem_read || c.mem_write) return IMM_D;
        if (c.alu_src)                return IMM_I;
        return IMM_R;
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch request, write-back port and the ID/EX register outputs.
interface id_stage_if #(
    parameter int DATA_W = 64,
    parameter int AW     = 5,
    parameter int CTRL_W = 12
);
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [DATA_W-1:0] if_pc;
    logic              id_ready;
    logic              flush;
    logic              wb_we;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_data1;
    logic [DATA_W-1:0] ex_data2;
    logic [DATA_W-1:0] ex_imm;
    logic [AW-1:0]     ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data,
        input  id_ready, ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rd, ex_ctrl
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data,
        output id_ready, ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rd, ex_ctrl
    );
endinterface

// File: rtl/id_control.sv
// Combinational LEGv8 opcode decoder; unknown opcodes decode to an all-zero NOP word.
module id_control
    import legv8_pkg::*;
(
    input  logic [10:0] opcode_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        // NOTE: defaulting every output first means no path leaves ctrl_o unassigned, so no latch.
        ctrl_o = '0;
        casez (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                ctrl_o.uses_rs2  = 1'b1;
                ctrl_o.alu_op    = 2'b10;
                ctrl_o.reg_write = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = 2'b10;
                ctrl_o.reg_write = 1'b1;
            end
            OP_LDUR: begin
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            OP_STUR: begin
                ctrl_o.reg2loc   = 1'b1;
                ctrl_o.uses_rs2  = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_B: begin
                ctrl_o.b = 1'b1;
            end
            OP_CBZ, OP_CBNZ: begin
                ctrl_o.reg2loc  = 1'b1;
                ctrl_o.uses_rs2 = 1'b1;
                ctrl_o.alu_op   = 2'b01;
                ctrl_o.cbz      = !opcode_i[3];
                ctrl_o.cbnz     = opcode_i[3];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// LEGv8 decode stage: register file with write-back bypass, immediate generation,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import legv8_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int CTRL_W = 12
)(
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);

    localparam logic [AW-1:0] XZR = AW'(NREGS - 1);

    logic [DATA_W-1:0] rf_q [NREGS];

    ctrl_t             ctrl;
    logic [AW-1:0]     rs1, rs2;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic              stall, issue;

    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_pc_q, ex_pc_d;
    logic [DATA_W-1:0] ex_data1_q, ex_data1_d;
    logic [DATA_W-1:0] ex_data2_q, ex_data2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [AW-1:0]     ex_rd_q, ex_rd_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;

    id_control u_control (
        .opcode_i (bus.if_instr[31:21]),
        .ctrl_o   (ctrl)
    );

    assign rs1 = bus.if_instr[5 +: AW];
    assign rs2 = ctrl.reg2loc ? bus.if_instr[0 +: AW] : bus.if_instr[16 +: AW];

    // XZR (and anything above it) reads as zero; a same-cycle write-back wins over the array.
    assign rd1 = (rs1 >= XZR) ? '0 :
                 (bus.wb_we && bus.wb_addr == rs1) ? bus.wb_data : rf_q[rs1];
    assign rd2 = (rs2 >= XZR) ? '0 :
                 (bus.wb_we && bus.wb_addr == rs2) ? bus.wb_data : rf_q[rs2];

    // NOTE: the register file sits on the async reset because every entry must read 0 afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (bus.wb_we && bus.wb_addr < XZR) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        imm = '0;
        unique case (imm_sel(ctrl))
            IMM_I:   imm = DATA_W'(bus.if_instr[21:10]);
            IMM_D:   imm = {{(DATA_W-9){bus.if_instr[20]}}, bus.if_instr[20:12]};
            IMM_CB:  imm = {{(DATA_W-21){bus.if_instr[23]}}, bus.if_instr[23:5], 2'b00};
            IMM_B:   imm = {{(DATA_W-28){bus.if_instr[25]}}, bus.if_instr[25:0], 2'b00};
            default: imm = '0;
        endcase
    end

    assign stall = bus.if_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != XZR) &&
                   ((ex_rd_q == rs1) || (ex_rd_q == rs2 && ctrl.uses_rs2));
    assign issue = bus.if_valid && !stall && !bus.flush;

    // Bubbles carry a zero control word so nothing can write downstream.
    assign ex_valid_d = issue;
    assign ex_ctrl_d  = issue ? ctrl : '0;
    assign ex_pc_d    = bus.if_pc;
    assign ex_data1_d = rd1;
    assign ex_data2_d = rd2;
    assign ex_imm_d   = imm;
    assign ex_rd_d    = bus.if_instr[0 +: AW];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_pc_q    <= '0;
            ex_data1_q <= '0;
            ex_data2_q <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_pc_q    <= ex_pc_d;
            ex_data1_q <= ex_data1_d;
            ex_data2_q <= ex_data2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign bus.id_ready = !stall;
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_pc    = ex_pc_q;
    assign bus.ex_data1 = ex_data1_q;
    assign bus.ex_data2 = ex_data2_q;
    assign bus.ex_imm   = ex_imm_q;
    assign bus.ex_rd    = ex_rd_q;
    assign bus.ex_ctrl  = CTRL_W'(ex_ctrl_q);

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios, a randomized run against an
// ISA-level reference model, and a short sweep of a 32-bit / 16-register instance.
module tb_id_stage;
    import legv8_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if #(.DATA_W(64), .AW(5), .CTRL_W(12)) bus ();
    id_stage #(.DATA_W(64), .NREGS(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    id_stage_if #(.DATA_W(32), .AW(4), .CTRL_W(12)) bus2 ();
    id_stage #(.DATA_W(32), .NREGS(16)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int errors = 0;
    int checks = 0;

    // Reference state: architectural registers plus the expected ID/EX contents.
    logic [63:0] m_rf [32];
    logic        m_valid;
    logic [63:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rd;
    ctrl_t       m_ctrl;
    logic        last_ready;
    logic        last_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, rn, rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] imm9, input logic [4:0] rn, rt);
        return {op, imm9, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm12, input logic [4:0] rn, rd);
        return {op, imm12, rn, rd};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm19, input logic [4:0] rt);
        return {op, imm19, rt};
    endfunction
    function automatic logic [31:0] enc_b(input logic [25:0] imm26);
        return {6'b000101, imm26};
    endfunction

    // ISA-level decode: fmt 0=R 1=I 2=D 3=CB 4=B.
    function automatic void ref_decode(input logic [31:0] ins, output ctrl_t c, output int fmt);
        int op;
        op  = int'(ins[31:21]);
        c   = '0;
        fmt = 0;
        if (op == 'h458 || op == 'h658 || op == 'h450 || op == 'h550) begin
            c.uses_rs2 = 1'b1; c.alu_op = 2'd2; c.reg_write = 1'b1;
        end else if ((op >> 1) == 'h244 || (op >> 1) == 'h344) begin
            c.alu_src = 1'b1; c.alu_op = 2'd2; c.reg_write = 1'b1; fmt = 1;
        end else if (op == 'h7C2) begin
            c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; fmt = 2;
        end else if (op == 'h7C0) begin
            c.reg2loc = 1'b1; c.uses_rs2 = 1'b1; c.alu_src = 1'b1; c.mem_write = 1'b1; fmt = 2;
        end else if ((op >> 5) == 5) begin
            c.b = 1'b1; fmt = 4;
        end else if ((op >> 3) == 'hB4 || (op >> 3) == 'hB5) begin
            c.reg2loc = 1'b1; c.uses_rs2 = 1'b1; c.alu_op = 2'd1; fmt = 3;
            if ((op >> 3) == 'hB4) c.cbz = 1'b1; else c.cbnz = 1'b1;
        end
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int fmt);
        logic signed [8:0]  d9;
        logic signed [18:0] c19;
        logic signed [25:0] b26;
        d9  = ins[20:12];
        c19 = ins[23:5];
        b26 = ins[25:0];
        case (fmt)
            1:       return {52'd0, ins[21:10]};
            2:       return 64'(longint'(d9));
            3:       return 64'(longint'(c19) * 4);
            4:       return 64'(longint'(b26) * 4);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] ref_read(input logic [4:0] r);
        if (r == 5'd31) return 64'd0;
        if (bus.wb_we && bus.wb_addr == r) return bus.wb_data;
        return m_rf[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
        m_valid = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0; m_rd = '0; m_ctrl = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ex_valid"}, 64'(bus.ex_valid), 64'd0);
        check({tag, " ex_pc"},    bus.ex_pc,         64'd0);
        check({tag, " ex_data1"}, bus.ex_data1,      64'd0);
        check({tag, " ex_data2"}, bus.ex_data2,      64'd0);
        check({tag, " ex_imm"},   bus.ex_imm,        64'd0);
        check({tag, " ex_rd"},    64'(bus.ex_rd),    64'd0);
        check({tag, " ex_ctrl"},  64'(bus.ex_ctrl),  64'd0);
    endtask

    // One clock of the main instance: check id_ready, step the model, check ID/EX.
    task automatic tick();
        ctrl_t       c;
        int          fmt;
        logic [4:0]  rs1, rs2;
        logic        stall, issue;
        logic [63:0] d1, d2;
        ref_decode(bus.if_instr, c, fmt);
        rs1   = bus.if_instr[9:5];
        rs2   = c.reg2loc ? bus.if_instr[4:0] : bus.if_instr[20:16];
        stall = bus.if_valid && m_valid && m_ctrl.mem_read && m_rd != 5'd31 &&
                (m_rd == rs1 || (m_rd == rs2 && c.uses_rs2));
        #1;
        last_ready = bus.id_ready;
        last_stall = stall;
        check("id_ready", 64'(bus.id_ready), 64'(!stall));
        issue = bus.if_valid && !bus.flush && !stall;
        d1 = ref_read(rs1);
        d2 = ref_read(rs2);
        @(posedge clk);
        if (issue) begin
            m_pc  = bus.if_pc;
            m_d1  = d1;
            m_d2  = d2;
            m_imm = ref_imm(bus.if_instr, fmt);
            m_rd  = bus.if_instr[4:0];
        end
        m_valid = issue;
        m_ctrl  = issue ? c : '0;
        if (bus.wb_we && bus.wb_addr != 5'd31) m_rf[bus.wb_addr] = bus.wb_data;
        #1;
        check("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
        check("ex_ctrl", 64'(bus.ex_ctrl), 64'(m_ctrl));
        if (m_valid) begin
            check("ex_pc", bus.ex_pc, m_pc);
            check("ex_data1", bus.ex_data1, m_d1);
            check("ex_data2", bus.ex_data2, m_d2);
            check("ex_imm", bus.ex_imm, m_imm);
            check("ex_rd", 64'(bus.ex_rd), 64'(m_rd));
        end
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 6);
        if (r == 6) return 5'($urandom_range(0, 31));
        if (r == 5) return 5'd31;
        return 5'(r);
    endfunction

    function automatic logic [31:0] pick_instr();
        case ($urandom_range(0, 7))
            0: begin
                logic [10:0] ops [4];
                ops = '{11'h458, 11'h658, 11'h450, 11'h550};
                return enc_r(ops[$urandom_range(0, 3)], pick_reg(), pick_reg(), pick_reg());
            end
            1: return enc_i($urandom_range(0, 1) ? 10'h244 : 10'h344, 12'($urandom), pick_reg(), pick_reg());
            2, 3: return enc_d(11'h7C2, 9'($urandom), pick_reg(), pick_reg());
            4: return enc_d(11'h7C0, 9'($urandom), pick_reg(), pick_reg());
            5: return enc_cb($urandom_range(0, 1) ? 8'hB4 : 8'hB5, 19'($urandom), pick_reg());
            6: return enc_b(26'($urandom));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        bus.if_valid = 0; bus.if_instr = '0; bus.if_pc = '0; bus.flush = 0;
        bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus2.if_valid = 0; bus2.if_instr = '0; bus2.if_pc = '0; bus2.flush = 0;
        bus2.wb_we = 0; bus2.wb_addr = '0; bus2.wb_data = '0;
        model_reset();
        last_stall = 1'b0;
        #2;
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b0;

        // Plain write while idle.
        bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 64'hDEAD;
        tick();

        // Same-cycle bypass: X3 written while ADD X1,X3,X3 decodes.
        bus.wb_addr = 5'd3; bus.wb_data = 64'h1234;
        bus.if_valid = 1; bus.if_pc = 64'h100; bus.if_instr = enc_r(11'h458, 5'd3, 5'd3, 5'd1);
        tick();
        check("bypass data1", bus.ex_data1, 64'h1234);
        check("bypass data2", bus.ex_data2, 64'h1234);

        // XZR write is discarded and XZR reads as zero even with a coincident write.
        bus.wb_addr = 5'd31; bus.wb_data = 64'hFFFF;
        bus.if_pc = 64'h104; bus.if_instr = enc_r(11'h458, 5'd2, 5'd31, 5'd1);
        tick();
        check("xzr data1", bus.ex_data1, 64'd0);

        // Load-use: LDUR X2,[X1,#8] then ADD X4,X2,X3 costs exactly one bubble.
        bus.wb_we = 0;
        bus.if_pc = 64'h108; bus.if_instr = enc_d(11'h7C2, 9'd8, 5'd1, 5'd2);
        tick();
        check("ldur imm", bus.ex_imm, 64'd8);
        bus.if_pc = 64'h10C; bus.if_instr = enc_r(11'h458, 5'd3, 5'd2, 5'd4);
        tick();
        check("load-use ready", 64'(last_ready), 64'd0);
        check("load-use bubble", 64'(bus.ex_valid), 64'd0);
        tick();
        check("load-use retry", 64'(bus.ex_valid), 64'd1);
        check("load-use rd", 64'(bus.ex_rd), 64'd4);

        // Flush kills a valid CBZ.
        bus.flush = 1; bus.if_pc = 64'h110; bus.if_instr = enc_cb(8'hB4, 19'd3, 5'd7);
        tick();
        check("flush cbz", 64'(bus.ex_valid), 64'd0);

        // Flush coinciding with a stall still yields a single bubble.
        bus.flush = 0; bus.if_pc = 64'h114; bus.if_instr = enc_d(11'h7C2, 9'd16, 5'd1, 5'd2);
        tick();
        bus.flush = 1; bus.if_pc = 64'h118; bus.if_instr = enc_r(11'h458, 5'd3, 5'd2, 5'd4);
        tick();
        check("flush+stall ready", 64'(last_ready), 64'd0);
        bus.flush = 0;
        tick();
        check("flush+stall ready after", 64'(last_ready), 64'd1);
        check("flush+stall issue", 64'(bus.ex_valid), 64'd1);

        // Immediate boundaries and an unknown opcode.
        bus.if_pc = 64'h11C; bus.if_instr = enc_b(26'h3FFFFFF);
        tick();
        check("b imm -4", bus.ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.if_pc = 64'h120; bus.if_instr = enc_cb(8'hB4, 19'd1, 5'd0);
        tick();
        check("cbz imm 4", bus.ex_imm, 64'd4);
        bus.if_pc = 64'h124; bus.if_instr = 32'h0000_0000;
        tick();
        check("nop valid", 64'(bus.ex_valid), 64'd1);
        check("nop ctrl", 64'(bus.ex_ctrl), 64'd0);

        // Mid-run asynchronous reset clears ID/EX and the register file.
        bus.if_valid = 0;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrun");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.if_valid = 1; bus.if_pc = 64'h200; bus.if_instr = enc_r(11'h458, 5'd5, 5'd5, 5'd1);
        tick();
        check("x5 after reset", bus.ex_data1, 64'd0);
        check("first issue after reset", 64'(bus.ex_valid), 64'd1);

        // Randomized traffic; fetch holds its instruction while id_ready is low.
        last_stall = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                bus.if_valid = ($urandom_range(0, 9) < 8);
                bus.if_instr = pick_instr();
                bus.if_pc    = {$urandom, $urandom};
            end
            bus.flush   = ($urandom_range(0, 9) == 0);
            bus.wb_we   = $urandom_range(0, 1);
            bus.wb_addr = pick_reg();
            bus.wb_data = {$urandom, $urandom};
            tick();
        end
        bus.if_valid = 0; bus.wb_we = 0; bus.flush = 0;

        // 32-bit / 16-register instance: XZR is X15.
        bus2.wb_we = 1; bus2.wb_addr = 4'd2; bus2.wb_data = 32'h55;
        @(posedge clk); #1;
        bus2.wb_addr = 4'd15; bus2.wb_data = 32'hFFFF;
        bus2.if_valid = 1; bus2.if_pc = 32'h100; bus2.if_instr = enc_r(11'h458, 5'd2, 5'd15, 5'd1);
        @(posedge clk); #1;
        check("w32 xzr data1", 64'(bus2.ex_data1), 64'd0);
        check("w32 data2", 64'(bus2.ex_data2), 64'h55);
        check("w32 pc", 64'(bus2.ex_pc), 64'h100);
        bus2.wb_we = 0; bus2.if_instr = enc_r(11'h458, 5'd15, 5'd15, 5'd1);
        @(posedge clk); #1;
        check("w32 xzr after write", 64'(bus2.ex_data2), 64'd0);
        bus2.if_instr = enc_b(26'h3FFFFFF);
        @(posedge clk); #1;
        check("w32 b imm", 64'(bus2.ex_imm), 64'hFFFF_FFFC);
        bus2.if_instr = enc_cb(8'hB4, 19'd1, 5'd3);
        @(posedge clk); #1;
        check("w32 cbz imm", 64'(bus2.ex_imm), 64'd4);
        bus2.if_instr = enc_d(11'h7C2, 9'd4, 5'd1, 5'd15);
        @(posedge clk); #1;
        bus2.if_instr = enc_r(11'h458, 5'd15, 5'd15, 5'd1);
        #1;
        check("w32 load to xzr no stall", 64'(bus2.id_ready), 64'd1);
        @(posedge clk); #1;
        check("w32 load to xzr issue", 64'(bus2.ex_valid), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
